// File: rtl/pe_stream_feeder.sv
// pe_stream_feeder: drains filter/ifmap FIFOs into local storage and streams
// sliding-window operand pairs to a PE over valid/ready.
module pe_stream_feeder #(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_FLTR   = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                      pe_clk,
   input  logic                      rstn,
   input  logic                      start,
   input  logic [$clog2(MAX_FLTR):0] cfg_fltr_len,
   input  logic [CNT_WIDTH-1:0]      cfg_ifmap_len,
   input  logic                      pre_fill_done_sync,
   input  logic                      fltr_empty,
   input  logic                      ifmap_empty,
   output logic                      fltr_rd_en,
   output logic                      ifmap_rd_en,
   input  logic [DATA_WIDTH-1:0]     fltr_rd_data,
   input  logic [DATA_WIDTH-1:0]     ifmap_rd_data,
   output logic                      pe_valid,
   input  logic                      pe_ready,
   output logic [DATA_WIDTH-1:0]     pe_ifmap,
   output logic [DATA_WIDTH-1:0]     pe_fltr,
   output logic                      pe_last,
   output logic [CNT_WIDTH-1:0]      pe_win_idx,
   output logic                      busy,
   output logic                      done,
   output logic                      cfg_err
);
   localparam int IW = $clog2(MAX_FLTR);
   localparam logic [IW:0] MAX_S = MAX_FLTR[IW:0];

   typedef enum logic [2:0] {IDLE, WAIT_FILL, LOAD_FLTR, LOAD_WIN, STREAM, SLIDE, DONE} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] fltr_mem [MAX_FLTR];
   logic [DATA_WIDTH-1:0] win [MAX_FLTR];
   logic [IW-1:0]         s_m1, rcv, k;
   logic [IW:0]           iss;
   logic [CNT_WIDTH-1:0]  last_o, o;
   logic                  f_pend, i_pend, cfg_ok;

   assign cfg_ok = cfg_fltr_len != '0 && cfg_fltr_len <= MAX_S &&
                   cfg_ifmap_len >= CNT_WIDTH'(cfg_fltr_len);
   // read strobes are combinational on the empty flags so a read is never issued into an empty FIFO
   assign fltr_rd_en  = state == LOAD_FLTR && !fltr_empty && iss <= {1'b0, s_m1};
   assign ifmap_rd_en = !ifmap_empty && (state == LOAD_WIN ? iss <= {1'b0, s_m1} :
                                         state == SLIDE && iss == '0);
   assign pe_valid   = state == STREAM;
   assign pe_ifmap   = win[k];
   assign pe_fltr    = fltr_mem[k];
   assign pe_last    = pe_valid && k == s_m1;
   assign pe_win_idx = o;
   assign busy       = state != IDLE;
   assign done       = state == DONE;

   always_ff @(posedge pe_clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         s_m1     <= '0;
         last_o   <= '0;
         iss      <= '0;
         rcv      <= '0;
         k        <= '0;
         o        <= '0;
         f_pend   <= 1'b0;
         i_pend   <= 1'b0;
         cfg_err  <= 1'b0;
         fltr_mem <= '{default: '0};
         win      <= '{default: '0};
      end else begin
         cfg_err <= 1'b0;
         f_pend  <= fltr_rd_en;
         i_pend  <= ifmap_rd_en;
         if (fltr_rd_en || ifmap_rd_en) iss <= iss + 1'b1;
         case (state)
            IDLE: begin
               if (start && cfg_ok) begin
                  s_m1   <= IW'(cfg_fltr_len - 1'b1);
                  last_o <= cfg_ifmap_len - CNT_WIDTH'(cfg_fltr_len);
                  iss    <= '0;
                  rcv    <= '0;
                  k      <= '0;
                  o      <= '0;
                  state  <= WAIT_FILL;
               end else begin
                  cfg_err <= start;
               end
            end
            WAIT_FILL: state <= pre_fill_done_sync ? LOAD_FLTR : WAIT_FILL;
            LOAD_FLTR: begin
               if (f_pend) begin
                  fltr_mem[rcv] <= fltr_rd_data;
                  rcv           <= rcv + 1'b1;
                  if (rcv == s_m1) begin
                     rcv   <= '0;
                     iss   <= '0;
                     state <= LOAD_WIN;
                  end
               end
            end
            LOAD_WIN: begin
               if (i_pend) begin
                  win[rcv] <= ifmap_rd_data;
                  rcv      <= rcv + 1'b1;
                  if (rcv == s_m1) begin
                     rcv   <= '0;
                     k     <= '0;
                     o     <= '0;
                     state <= STREAM;
                  end
               end
            end
            STREAM: begin
               if (pe_ready) begin
                  k <= k == s_m1 ? '0 : k + 1'b1;
                  if (k == s_m1) begin
                     iss   <= '0;
                     state <= o == last_o ? DONE : SLIDE;
                  end
               end
            end
            SLIDE: begin
               if (i_pend) begin
                  for (int i = 0; i < MAX_FLTR - 1; i++) win[i] <= win[i+1];
                  win[s_m1] <= ifmap_rd_data;
                  o         <= o + 1'b1;
                  state     <= STREAM;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pe_stream_feeder.sv
// tb_pe_stream_feeder: directed jobs against FIFO models and a window-pair scoreboard.
module tb_pe_stream_feeder;
   logic        pe_clk = 0, rstn = 0, start = 0, pre_fill_done_sync = 0, pe_ready = 0;
   logic [3:0]  cfg_fltr_len = 0;
   logic [7:0]  cfg_ifmap_len = 0;
   logic        fltr_empty, ifmap_empty, fltr_rd_en, ifmap_rd_en;
   logic [15:0] fltr_rd_data = 0, ifmap_rd_data = 0, pe_ifmap, pe_fltr;
   logic        pe_valid, pe_last, busy, done, cfg_err;
   logic [7:0]  pe_win_idx;
   logic [40:0] pay, held;
   int          vectors = 0, errs = 0;
   logic [15:0] f_mem [256], i_mem [256];
   int          f_wr = 0, f_rd = 0, i_wr = 0, i_rd = 0, f_reads = 0, i_reads = 0;
   logic        f_flush = 0, i_hold = 0, stall = 0;
   logic [15:0] exp_if [256], exp_f [256];
   logic        exp_l [256];
   logic [7:0]  exp_o [256];
   int          n_exp = 0, idx = 0, skip_to = 0;
   logic [15:0] fltr_v [16], ifmap_v [16];

   always #5 pe_clk = ~pe_clk;

   assign fltr_empty  = f_rd == f_wr;
   assign ifmap_empty = i_hold || i_rd == i_wr;
   assign pay         = {pe_ifmap, pe_fltr, pe_last, pe_win_idx};

   pe_stream_feeder dut (
      .pe_clk(pe_clk), .rstn(rstn), .start(start), .cfg_fltr_len(cfg_fltr_len),
      .cfg_ifmap_len(cfg_ifmap_len), .pre_fill_done_sync(pre_fill_done_sync),
      .fltr_empty(fltr_empty), .ifmap_empty(ifmap_empty), .fltr_rd_en(fltr_rd_en),
      .ifmap_rd_en(ifmap_rd_en), .fltr_rd_data(fltr_rd_data), .ifmap_rd_data(ifmap_rd_data),
      .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_ifmap(pe_ifmap), .pe_fltr(pe_fltr),
      .pe_last(pe_last), .pe_win_idx(pe_win_idx), .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      vectors++;
      if (act !== want) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, want);
      end
   endtask

   // FIFO read side: data registered one cycle after an accepted read
   always @(posedge pe_clk) begin
      if (f_flush) begin
         f_rd <= f_wr;
         i_rd <= i_wr;
      end else begin
         if (fltr_rd_en) begin
            fltr_rd_data <= f_mem[f_rd];
            f_rd         <= f_rd + 1;
            f_reads      <= f_reads + 1;
         end
         if (ifmap_rd_en) begin
            ifmap_rd_data <= i_mem[i_rd];
            i_rd          <= i_rd + 1;
            i_reads       <= i_reads + 1;
         end
      end
   end

   always @(negedge pe_clk) begin
      if (!rstn) begin
         idx   = skip_to;
         stall = 0;
      end else begin
         chk("rd_while_empty", 64'({fltr_rd_en & fltr_empty, ifmap_rd_en & ifmap_empty}), 64'd0);
         if (stall) chk("stall_hold", 64'({pe_valid, pay}), 64'({1'b1, held}));
         if (pe_valid && pe_ready) begin
            chk("pair_in_range", 64'(idx < n_exp), 64'd1);
            if (idx < n_exp)
               chk($sformatf("pair%0d", idx), 64'(pay),
                   64'({exp_if[idx], exp_f[idx], exp_l[idx], exp_o[idx]}));
            idx++;
         end
         stall = pe_valid && !pe_ready;
         held  = pay;
      end
   end

   task automatic set_vals(input int s, w, fb, fs, ib, is);
      for (int i = 0; i < s; i++) fltr_v[i] = 16'(fb + i * fs);
      for (int i = 0; i < w; i++) ifmap_v[i] = 16'(ib + i * is);
   endtask

   task automatic push_job(input int s, w);
      for (int i = 0; i < s; i++) begin f_mem[f_wr] = fltr_v[i]; f_wr++; end
      for (int i = 0; i < w; i++) begin i_mem[i_wr] = ifmap_v[i]; i_wr++; end
   endtask

   // window o pairs filter tap j with ifmap element o+j
   task automatic add_exp(input int s, w);
      for (int o = 0; o <= w - s; o++)
         for (int j = 0; j < s; j++) begin
            exp_if[n_exp] = ifmap_v[o+j];
            exp_f[n_exp]  = fltr_v[j];
            exp_l[n_exp]  = j == s - 1;
            exp_o[n_exp]  = 8'(o);
            n_exp++;
         end
   endtask

   task automatic run_job(input int s, w, input bit tgl, hold, input int pf_delay);
      int fb, ib, dn, first, hold_left;
      bit fin, hold_arm;
      push_job(s, w);
      add_exp(s, w);
      fb = f_reads; ib = i_reads; dn = 0; first = -1; hold_left = 0; fin = 0; hold_arm = hold;
      pre_fill_done_sync = pf_delay == 0;
      pe_ready = 1;
      cfg_fltr_len = 4'(s);
      cfg_ifmap_len = 8'(w);
      start = 1;
      for (int c = 1; c <= 600 && !fin; c++) begin
         @(posedge pe_clk); #1;
         start = 0;
         if (tgl) pe_ready = ~pe_ready;
         if (c == pf_delay) begin
            chk("no_read_before_fill", 64'((f_reads - fb) + (i_reads - ib)), 64'd0);
            pre_fill_done_sync = 1;
         end
         #2;
         if (c == 1) chk("busy_rise", 64'(busy), 64'd1);
         if (hold_left > 0) begin
            chk("hold_rd_en", 64'(ifmap_rd_en), 64'd0);
            chk("hold_valid", 64'(pe_valid), 64'd0);
            hold_left--;
            if (hold_left == 0) i_hold = 0;
         end else if (hold_arm && pe_valid && pe_ready && pe_last) begin
            i_hold = 1;
            hold_left = 4;
            hold_arm = 0;
         end
         if (pe_valid && first < 0) first = c;
         if (dn > 0) begin
            chk("busy_fall", 64'(busy), 64'd0);
            fin = 1;
         end
         if (done) dn++;
      end
      chk("job_finished", 64'(fin), 64'd1);
      chk("done_count", 64'(dn), 64'd1);
      chk("fltr_reads", 64'(f_reads - fb), 64'(s));
      chk("ifmap_reads", 64'(i_reads - ib), 64'(w));
      chk("pairs_consumed", 64'(idx), 64'(n_exp));
      if (!tgl && !hold && pf_delay == 0) chk("first_valid_latency", 64'(first), 64'(2 * s + 4));
   endtask

   task automatic cfg_bad(input int s, w);
      int fb, ib;
      fb = f_reads; ib = i_reads;
      cfg_fltr_len = 4'(s);
      cfg_ifmap_len = 8'(w);
      start = 1;
      @(posedge pe_clk); #1;
      start = 0;
      #2;
      chk($sformatf("cfg_err_s%0d_w%0d", s, w), 64'({cfg_err, busy}), 64'b10);
      @(posedge pe_clk); #3;
      chk("cfg_err_pulse_end", 64'({cfg_err, busy}), 64'b00);
      chk("cfg_err_no_reads", 64'((f_reads - fb) + (i_reads - ib)), 64'd0);
   endtask

   initial begin
      int b;
      bit reached;
      repeat (3) @(posedge pe_clk);
      #1;
      chk("reset_outputs", 64'({pe_valid, pay, fltr_rd_en, ifmap_rd_en, busy, done, cfg_err}), 64'd0);
      rstn = 1;
      @(posedge pe_clk); #1;
      // basic job: S=3, W=5
      set_vals(3, 5, 1, 1, 10, 1);
      b = n_exp;
      run_job(3, 5, 0, 0, 0);
      chk("pin_pair0", 64'({exp_if[b], exp_f[b], exp_l[b], exp_o[b]}), 64'({16'd10, 16'd1, 1'b0, 8'd0}));
      chk("pin_pair2", 64'({exp_if[b+2], exp_f[b+2], exp_l[b+2], exp_o[b+2]}), 64'({16'd12, 16'd3, 1'b1, 8'd0}));
      chk("pin_pair5", 64'({exp_if[b+5], exp_f[b+5], exp_l[b+5], exp_o[b+5]}), 64'({16'd13, 16'd3, 1'b1, 8'd1}));
      chk("pin_pair8", 64'({exp_if[b+8], exp_f[b+8], exp_l[b+8], exp_o[b+8]}), 64'({16'd14, 16'd3, 1'b1, 8'd2}));
      chk("pin_count", 64'(n_exp - b), 64'd9);
      run_job(3, 5, 1, 0, 0);
      run_job(3, 5, 0, 1, 0);
      cfg_bad(0, 5);
      cfg_bad(3, 2);
      cfg_bad(9, 20);
      set_vals(3, 5, 100, 3, 200, 7);
      run_job(3, 5, 0, 0, 10);
      set_vals(1, 4, 7, 0, 40, 1);
      b = n_exp;
      run_job(1, 4, 0, 0, 0);
      chk("pin_s1_first", 64'({exp_if[b], exp_f[b], exp_l[b], exp_o[b]}), 64'({16'd40, 16'd7, 1'b1, 8'd0}));
      chk("pin_s1_last", 64'({exp_if[b+3], exp_f[b+3], exp_l[b+3], exp_o[b+3]}), 64'({16'd43, 16'd7, 1'b1, 8'd3}));
      // abort a job mid-stream with reset, then run a fresh job
      set_vals(3, 5, 1, 1, 10, 1);
      push_job(3, 5);
      add_exp(3, 5);
      skip_to = n_exp;
      b = idx;
      reached = 0;
      pre_fill_done_sync = 1;
      pe_ready = 1;
      cfg_fltr_len = 4'd3;
      cfg_ifmap_len = 8'd5;
      start = 1;
      for (int c = 0; c < 100 && !reached; c++) begin
         @(posedge pe_clk); #1;
         start = 0;
         reached = idx - b >= 2;
      end
      chk("abort_reached_stream", 64'(reached), 64'd1);
      rstn = 0;
      #1;
      chk("abort_outputs", 64'({pe_valid, pay, fltr_rd_en, ifmap_rd_en, busy, done, cfg_err}), 64'd0);
      f_flush = 1;
      @(posedge pe_clk); #1;
      f_flush = 0;
      rstn = 1;
      set_vals(2, 6, 50, 5, 300, 11);
      run_job(2, 6, 0, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
